fifo_stream_reader: RTL

//  Read-side drain stage attached directly to the FIFO memory read port (rd_en/data_out/FIFO_empty).

---
 rtl/fifo_stream_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain stage: pops words from a registered-read FIFO and presents them as a
// PKT_LEN-framed valid/ready stream, with start/stop control that respects frame boundaries.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [BW-1:0]         r_fetch_cnt;
  logic [BW-1:0]         r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [CNT_WIDTH-1:0]  r_words_sent;

  logic                  w_xfer;
  logic                  w_allow;
  logic                  w_room;
  logic [2:0]            w_pending;

  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_buf0;
  assign m_last     = m_valid & (r_beat_cnt == LAST_BEAT);
  assign busy       = (r_state != ST_IDLE);
  assign words_sent = r_words_sent;

  assign w_xfer    = m_valid & m_ready;
  // Count the word already in flight so the buffer can never be overrun by the read latency.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_room    = (w_pending < 3'd2);
  assign w_allow   = (r_state == ST_ACTIVE) |
                     ((r_state == ST_STOPPING) & (r_fetch_cnt != '0));
  assign fifo_rd_en = ~fifo_empty & w_room & w_allow;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!enable) w_state_next = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (enable)
          w_state_next = ST_ACTIVE;
        else if ((r_fetch_cnt == '0) && !r_inflight && (r_occ == 2'd0))
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Two-entry buffer: buf0 is the head; capture and transfer in the same cycle keep occ steady.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      case ({r_inflight, w_xfer})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= fifo_data_out;
          else               r_buf1 <= fifo_data_out;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_data_out;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_fetch_cnt  <= '0;
      r_beat_cnt   <= '0;
      r_words_sent <= '0;
    end else begin
      if (fifo_rd_en)
        r_fetch_cnt <= (r_fetch_cnt == LAST_BEAT) ? '0 : r_fetch_cnt + 1'b1;
      if (w_xfer) begin
        r_beat_cnt   <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
        r_words_sent <= r_words_sent + 1'b1;
      end
    end
  end

endmodule
